lcd_host_seq: RTL

- Host-side command sequencer that drives the LCD display controller's command/data interface.
- Accepts display commands from an upstream script port.
- Issues each command to the controller with cmd/cmd_valid, honouring busy. For LOAD, streams the image from a pixel ROM on datain.
- Captures each 16-pixel display burst (dataout/output_valid) and forwards it, indexed, to a result port, with count and timeout checking.

---
 rtl/lcd_host_seq_if.sv | 37 +++
 rtl/lcd_host_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lcd_host_seq_if.sv
// Signal bundle between the LCD host sequencer and its surroundings: script port,
// image ROM, LCD controller command/data interface and the captured-pixel result port.
interface lcd_host_seq_if #(
    parameter int AW = 7
);
    logic [3:0]    scr_cmd;
    logic          scr_valid;
    logic          scr_ready;
    logic          img_rd;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_data;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [7:0]    datain;
    logic          busy;
    logic [7:0]    dataout;
    logic          output_valid;
    logic [7:0]    pix_out;
    logic [3:0]    pix_idx;
    logic          pix_valid;
    logic          frame_done;
    logic          err_cnt;
    logic          err_to;
    logic          err_cmd;

    modport master (
        input  scr_cmd, scr_valid, img_data, busy, dataout, output_valid,
        output scr_ready, img_rd, img_addr, cmd, cmd_valid, datain,
               pix_out, pix_idx, pix_valid, frame_done, err_cnt, err_to, err_cmd
    );

    modport slave (
        output scr_cmd, scr_valid, img_data, busy, dataout, output_valid,
        input  scr_ready, img_rd, img_addr, cmd, cmd_valid, datain,
               pix_out, pix_idx, pix_valid, frame_done, err_cnt, err_to, err_cmd
    );
endinterface

// File: rtl/lcd_host_seq.sv
// Host-side command sequencer for the LCD controller: issues script commands, streams the
// image ROM on LOAD, and captures each display burst with count and timeout checking.
module lcd_host_seq #(
    parameter int IMG_PIX  = 108,
    parameter int DISP_PIX = 16,
    parameter int AW       = 7,
    parameter int TIMEOUT  = 512
) (
    input  logic           clk,
    input  logic           reset,
    lcd_host_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD,
        S_WAIT,
        S_DRAIN
    } state_t;

    localparam int LW = $clog2(IMG_PIX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0]    CMD_LOAD = 4'd0;
    localparam logic [3:0]    CMD_MAX  = 4'd8;
    localparam logic [LW-1:0] LD_LAST  = LW'(IMG_PIX);
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT);
    localparam logic [4:0]    CNT_EXP  = 5'(DISP_PIX);
    localparam logic [4:0]    CNT_SAT  = 5'd31;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cmd;
    logic [LW-1:0] r_ld;
    logic [TW-1:0] r_tmo;
    logic          r_first;
    logic [4:0]    r_cnt;
    logic [7:0]    r_cap;
    logic [3:0]    r_cap_idx;
    logic          r_cap_v;
    logic          r_err_cnt;
    logic          r_err_to;
    logic          r_err_cmd;

    logic w_ready;
    logic w_accept;
    logic w_bad;
    logic w_tmo;

    // Reset is folded in so the script port reads not-ready during the reset cycle itself.
    assign w_ready  = reset && (r_state == S_IDLE) && !bus.busy;
    assign w_accept = w_ready && bus.scr_valid && (bus.scr_cmd <= CMD_MAX);
    assign w_bad    = w_ready && bus.scr_valid && (bus.scr_cmd >  CMD_MAX);
    assign w_tmo    = ((r_state == S_LOAD) || (r_state == S_WAIT)) && (r_tmo == TO_LIM);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next         = r_state;
        bus.scr_ready  = w_ready;
        bus.cmd_valid  = 1'b0;
        bus.cmd        = 4'd0;
        bus.img_rd     = 1'b0;
        bus.img_addr   = '0;
        bus.datain     = 8'd0;
        bus.frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                bus.cmd_valid = 1'b1;
                bus.cmd       = r_cmd;
                if (r_cmd == CMD_LOAD) begin
                    bus.img_rd = 1'b1;
                    w_next     = S_LOAD;
                end else begin
                    w_next     = S_WAIT;
                end
            end
            S_LOAD: begin
                // ROM is one cycle ahead: address k is presented while pixel k-1 is on datain.
                bus.datain = bus.img_data;
                if (r_ld != LD_LAST) begin
                    bus.img_rd   = 1'b1;
                    bus.img_addr = AW'(r_ld);
                end
                if (w_tmo)                 w_next = S_IDLE;
                else if (r_ld == LD_LAST)  w_next = S_WAIT;
            end
            S_WAIT: begin
                // r_first masks the cycle before the controller has had a chance to raise busy.
                if (w_tmo)                         w_next = S_IDLE;
                else if (!r_first && !bus.busy)    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                bus.frame_done = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cmd     <= 4'd0;
            r_ld      <= '0;
            r_tmo     <= '0;
            r_first   <= 1'b0;
            r_cnt     <= 5'd0;
            r_cap     <= 8'd0;
            r_cap_idx <= 4'd0;
            r_cap_v   <= 1'b0;
            r_err_cnt <= 1'b0;
            r_err_to  <= 1'b0;
            r_err_cmd <= 1'b0;
        end else begin
            r_first <= (r_state != S_WAIT);
            r_cap_v <= 1'b0;
            if (w_accept) r_cmd     <= bus.scr_cmd;
            if (w_bad)    r_err_cmd <= 1'b1;
            if (w_tmo)    r_err_to  <= 1'b1;
            case (r_state)
                S_ISSUE: begin
                    r_ld  <= LW'(1);
                    r_tmo <= TW'(1);
                    r_cnt <= 5'd0;
                end
                S_LOAD: begin
                    r_ld  <= r_ld + 1'b1;
                    r_tmo <= r_tmo + 1'b1;
                end
                S_WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (bus.output_valid) begin
                        r_cap     <= bus.dataout;
                        r_cap_idx <= r_cnt[3:0];
                        r_cap_v   <= 1'b1;
                        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt != CNT_EXP) r_err_cnt <= 1'b1;
                    r_cnt <= 5'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.pix_out   = r_cap;
    assign bus.pix_idx   = r_cap_idx;
    assign bus.pix_valid = r_cap_v;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.err_to    = r_err_to;
    assign bus.err_cmd   = r_err_cmd;
endmodule
